// File: rtl/noc_pkg.sv
// Shared NoC router definitions: port indices, code widths and the
// per-output allocator state record.
package noc_pkg;

  localparam int NPORTS   = 5;
  localparam int REQ_W    = 3;
  localparam int REQ_IDLE = 7;
  localparam int FLIT_W   = 8;

  typedef logic [REQ_W-1:0] port_idx_t;

  localparam port_idx_t PORT_L = 3'd0;
  localparam port_idx_t PORT_N = 3'd1;
  localparam port_idx_t PORT_E = 3'd2;
  localparam port_idx_t PORT_S = 3'd3;
  localparam port_idx_t PORT_W = 3'd4;

  typedef struct packed {
    logic      lock;
    port_idx_t owner;
    port_idx_t ptr;
  } out_state_t;

  // Round-robin pointer advance, wrapping 4 -> 0.
  function automatic port_idx_t next_ptr(input port_idx_t idx);
    return (idx >= port_idx_t'(NPORTS - 1)) ? port_idx_t'(0) : idx + port_idx_t'(1);
  endfunction

endpackage

// File: rtl/rr_arb5.sv
// Five-way round-robin arbiter: first requester at or after ptr_i, searching
// cyclically. Purely combinational.
module rr_arb5
  import noc_pkg::*;
(
  input  logic [NPORTS-1:0] req_i,
  input  port_idx_t         ptr_i,
  output logic [NPORTS-1:0] gnt_oh_o,
  output port_idx_t         gnt_idx_o
);

  always_comb begin
    logic found;
    int   idx;
    gnt_oh_o  = '0;
    gnt_idx_o = port_idx_t'(REQ_IDLE);
    found     = 1'b0;
    for (int k = 0; k < NPORTS; k++) begin
      idx = int'(ptr_i) + k;
      if (idx >= NPORTS) idx = idx - NPORTS;
      if (!found && req_i[idx]) begin
        found          = 1'b1;
        gnt_oh_o[idx]  = 1'b1;
        gnt_idx_o      = port_idx_t'(idx);
      end
    end
  end

endmodule

// File: rtl/switch_alloc.sv
// Wormhole switch allocator for the 5-port router: per-output round-robin
// arbitration, packet lock until tail transfer, grant and crossbar select.
module switch_alloc #(
  parameter int NPORTS   = 5,
  parameter int REQ_W    = 3,
  parameter int REQ_IDLE = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REQ_W-1:0] request_L,
  input  logic [REQ_W-1:0] request_N,
  input  logic [REQ_W-1:0] request_E,
  input  logic [REQ_W-1:0] request_S,
  input  logic [REQ_W-1:0] request_W,
  input  logic             tail_L,
  input  logic             tail_N,
  input  logic             tail_E,
  input  logic             tail_S,
  input  logic             tail_W,
  input  logic             full_L,
  input  logic             full_N,
  input  logic             full_E,
  input  logic             full_S,
  input  logic             full_W,
  output logic             grant_L,
  output logic             grant_N,
  output logic             grant_E,
  output logic             grant_S,
  output logic             grant_W,
  output logic [REQ_W-1:0] sel_L,
  output logic [REQ_W-1:0] sel_N,
  output logic [REQ_W-1:0] sel_E,
  output logic [REQ_W-1:0] sel_S,
  output logic [REQ_W-1:0] sel_W,
  output logic             busy_L,
  output logic             busy_N,
  output logic             busy_E,
  output logic             busy_S,
  output logic             busy_W
);
  import noc_pkg::*;

  logic [REQ_W-1:0]  req [NPORTS];
  logic [NPORTS-1:0] tail_v, full_v;
  logic [NPORTS-1:0] owns, xfer, rel, grant_v, busy_v;
  logic [NPORTS-1:0] cand   [NPORTS];
  logic [NPORTS-1:0] win_oh [NPORTS];
  port_idx_t         win_idx [NPORTS];
  logic [REQ_W-1:0]  sel_v  [NPORTS];
  out_state_t        st_q   [NPORTS];
  out_state_t        st_d   [NPORTS];

  assign req[0] = request_L;
  assign req[1] = request_N;
  assign req[2] = request_E;
  assign req[3] = request_S;
  assign req[4] = request_W;
  assign tail_v = {tail_W, tail_S, tail_E, tail_N, tail_L};
  assign full_v = {full_W, full_S, full_E, full_N, full_L};

  // An input holding a lock may not compete for any other output.
  always_comb begin
    owns = '0;
    for (int o = 0; o < NPORTS; o++)
      for (int i = 0; i < NPORTS; i++)
        if (st_q[o].lock && st_q[o].owner == port_idx_t'(i)) owns[i] = 1'b1;
  end

  // Codes 5..7 never match an output index, so they drop out as idle here.
  always_comb begin
    for (int o = 0; o < NPORTS; o++)
      for (int i = 0; i < NPORTS; i++)
        cand[o][i] = (req[i] == REQ_W'(o)) && !owns[i];
  end

  for (genvar o = 0; o < NPORTS; o++) begin : g_arb
    rr_arb5 u_arb (
      .req_i     (cand[o]),
      .ptr_i     (st_q[o].ptr),
      .gnt_oh_o  (win_oh[o]),
      .gnt_idx_o (win_idx[o])
    );
  end

  // Transfer only while the owner still targets this output and it has room.
  always_comb begin
    xfer = '0;
    rel  = '0;
    for (int o = 0; o < NPORTS; o++)
      for (int i = 0; i < NPORTS; i++)
        if (st_q[o].lock && st_q[o].owner == port_idx_t'(i)) begin
          xfer[o] = (req[i] == REQ_W'(o)) && !full_v[o];
          rel[o]  = (req[i] == REQ_W'(o)) && !full_v[o] && tail_v[i];
        end
  end

  always_comb begin
    grant_v = '0;
    for (int i = 0; i < NPORTS; i++)
      for (int o = 0; o < NPORTS; o++)
        if (xfer[o] && st_q[o].owner == port_idx_t'(i)) grant_v[i] = 1'b1;
  end

  always_comb begin
    for (int o = 0; o < NPORTS; o++) begin
      st_d[o] = st_q[o];
      if (st_q[o].lock) begin
        if (rel[o]) st_d[o].lock = 1'b0;
      end else if (|win_oh[o]) begin
        st_d[o].lock  = 1'b1;
        st_d[o].owner = win_idx[o];
        st_d[o].ptr   = next_ptr(win_idx[o]);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int o = 0; o < NPORTS; o++) begin
      if (!rst) st_q[o] <= '0;
      else      st_q[o] <= st_d[o];
    end
  end

  always_comb begin
    for (int o = 0; o < NPORTS; o++) begin
      busy_v[o] = st_q[o].lock;
      sel_v[o]  = st_q[o].lock ? st_q[o].owner : REQ_W'(REQ_IDLE);
    end
  end

  assign {grant_W, grant_S, grant_E, grant_N, grant_L} = grant_v;
  assign {busy_W, busy_S, busy_E, busy_N, busy_L}      = busy_v;
  assign sel_L = sel_v[0];
  assign sel_N = sel_v[1];
  assign sel_E = sel_v[2];
  assign sel_S = sel_v[3];
  assign sel_W = sel_v[4];

endmodule

// File: tb/tb_switch_alloc.sv
// Directed bench for switch_alloc: reset, round-robin, wormhole lock,
// backpressure, parallel traffic, idle codes and reset mid-packet.
module tb_switch_alloc;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] req [5];
  logic [4:0] tail, full;
  wire        gL, gN, gE, gS, gW, bL, bN, bE, bS, bW;
  logic [2:0] sel [5];
  logic [4:0] gnt, busy;
  int         total = 0;
  int         bad   = 0;

  assign gnt  = {gW, gS, gE, gN, gL};
  assign busy = {bW, bS, bE, bN, bL};

  always #5 clk = ~clk;

  switch_alloc dut (
    .clk(clk), .rst(rst),
    .request_L(req[0]), .request_N(req[1]), .request_E(req[2]),
    .request_S(req[3]), .request_W(req[4]),
    .tail_L(tail[0]), .tail_N(tail[1]), .tail_E(tail[2]),
    .tail_S(tail[3]), .tail_W(tail[4]),
    .full_L(full[0]), .full_N(full[1]), .full_E(full[2]),
    .full_S(full[3]), .full_W(full[4]),
    .grant_L(gL), .grant_N(gN), .grant_E(gE), .grant_S(gS), .grant_W(gW),
    .sel_L(sel[0]), .sel_N(sel[1]), .sel_E(sel[2]), .sel_S(sel[3]), .sel_W(sel[4]),
    .busy_L(bL), .busy_N(bN), .busy_E(bE), .busy_S(bS), .busy_W(bW)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 5; i++) req[i] = 3'd7;
    tail = '0;
    full = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst  = 1'b0;
    for (int i = 0; i < 5; i++) req[i] = 3'd0;
    tail = '0;
    full = '0;
    cyc();
    #1;
    total++;
    if (gnt !== 5'b0 || busy !== 5'b0) begin
      bad++; $display("FAIL reset_outs: grant=%b busy=%b want 00000/00000", gnt, busy);
    end
    for (int o = 0; o < 5; o++) begin
      total++;
      if (sel[o] !== 3'd7) begin
        bad++; $display("FAIL reset_sel%0d: got %0d want 7", o, sel[o]);
      end
    end
    rst = 1'b1;
    #1;
    total++;
    if (busy !== 5'b0) begin
      bad++; $display("FAIL reset_release_busy: got %b want 00000", busy);
    end
    cyc();
    #1;
    total++;
    if (sel[0] !== 3'd0 || busy !== 5'b00001 || gnt !== 5'b00001) begin
      bad++; $display("FAIL reset_first_lock: sel_L=%0d busy=%b grant=%b want 0/00001/00001", sel[0], busy, gnt);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 5; i++) req[i] = 3'd2;
    tail = 5'b11111;
    #1;
    total++;
    if (sel[2] !== 3'd7 || gnt !== 5'b0) begin
      bad++; $display("FAIL rr_pre: sel_E=%0d grant=%b want 7/00000", sel[2], gnt);
    end
    cyc();
    for (int k = 0; k < 6; k++) begin
      #1;
      total++;
      if (sel[2] !== 3'(k % 5) || gnt !== 5'(1 << (k % 5))) begin
        bad++; $display("FAIL rr_grant%0d: sel_E=%0d grant=%b want %0d/%b", k, sel[2], gnt, k % 5, 5'(1 << (k % 5)));
      end
      cyc();
      #1;
      total++;
      if (sel[2] !== 3'd7 || gnt !== 5'b0 || busy[2] !== 1'b0) begin
        bad++; $display("FAIL rr_bubble%0d: sel_E=%0d grant=%b busy_E=%b want 7/00000/0", k, sel[2], gnt, busy[2]);
      end
      cyc();
    end
  endtask

  task automatic test_wormhole();
    do_reset();
    req[1] = 3'd3;
    req[4] = 3'd3;
    cyc();
    for (int f = 1; f <= 4; f++) begin
      tail[1] = (f == 4);
      #1;
      total++;
      if (gnt !== 5'b00010 || sel[3] !== 3'd1) begin
        bad++; $display("FAIL worm_flit%0d: grant=%b sel_S=%0d want 00010/1", f, gnt, sel[3]);
      end
      cyc();
    end
    req[1]  = 3'd7;
    tail[1] = 1'b0;
    #1;
    total++;
    if (gnt !== 5'b0 || sel[3] !== 3'd7 || busy[3] !== 1'b0) begin
      bad++; $display("FAIL worm_bubble: grant=%b sel_S=%0d busy_S=%b want 00000/7/0", gnt, sel[3], busy[3]);
    end
    cyc();
    #1;
    total++;
    if (gnt !== 5'b10000 || sel[3] !== 3'd4) begin
      bad++; $display("FAIL worm_next: grant=%b sel_S=%0d want 10000/4", gnt, sel[3]);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    req[0] = 3'd1;
    cyc();
    #1;
    total++;
    if (gnt !== 5'b00001 || sel[1] !== 3'd0) begin
      bad++; $display("FAIL bp_first: grant=%b sel_N=%0d want 00001/0", gnt, sel[1]);
    end
    cyc();
    full[1] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (gnt !== 5'b0 || busy[1] !== 1'b1 || sel[1] !== 3'd0) begin
        bad++; $display("FAIL bp_stall%0d: grant=%b busy_N=%b sel_N=%0d want 00000/1/0", c, gnt, busy[1], sel[1]);
      end
      cyc();
    end
    full[1] = 1'b0;
    tail[0] = 1'b1;
    #1;
    total++;
    if (gnt !== 5'b00001 || sel[1] !== 3'd0) begin
      bad++; $display("FAIL bp_resume: grant=%b sel_N=%0d want 00001/0", gnt, sel[1]);
    end
    cyc();
    req[0]  = 3'd7;
    tail[0] = 1'b0;
    #1;
    total++;
    if (busy[1] !== 1'b0 || sel[1] !== 3'd7) begin
      bad++; $display("FAIL bp_release: busy_N=%b sel_N=%0d want 0/7", busy[1], sel[1]);
    end
  endtask

  task automatic test_parallel();
    logic [2:0] exp_sel [5];
    do_reset();
    req[0] = 3'd2; req[1] = 3'd4; req[2] = 3'd3; req[3] = 3'd0; req[4] = 3'd1;
    exp_sel[0] = 3'd3; exp_sel[1] = 3'd4; exp_sel[2] = 3'd0; exp_sel[3] = 3'd2; exp_sel[4] = 3'd1;
    cyc();
    #1;
    total++;
    if (gnt !== 5'b11111 || busy !== 5'b11111) begin
      bad++; $display("FAIL par_grant: grant=%b busy=%b want 11111/11111", gnt, busy);
    end
    for (int o = 0; o < 5; o++) begin
      total++;
      if (sel[o] !== exp_sel[o]) begin
        bad++; $display("FAIL par_sel%0d: got %0d want %0d", o, sel[o], exp_sel[o]);
      end
    end
  endtask

  task automatic test_idle_codes();
    do_reset();
    req[0] = 3'd7; req[1] = 3'd5; req[2] = 3'd6; req[3] = 3'd7; req[4] = 3'd5;
    cyc();
    cyc();
    #1;
    total++;
    if (busy !== 5'b0 || gnt !== 5'b0) begin
      bad++; $display("FAIL idle_nolock: busy=%b grant=%b want 00000/00000", busy, gnt);
    end
    for (int o = 0; o < 5; o++) begin
      total++;
      if (sel[o] !== 3'd7) begin
        bad++; $display("FAIL idle_sel%0d: got %0d want 7", o, sel[o]);
      end
    end
    req[2] = 3'd0;
    cyc();
    #1;
    total++;
    if (gnt !== 5'b00100 || sel[0] !== 3'd2) begin
      bad++; $display("FAIL idle_lock: grant=%b sel_L=%0d want 00100/2", gnt, sel[0]);
    end
    req[2] = 3'd7;
    req[3] = 3'd0;
    #1;
    total++;
    if (gnt !== 5'b0 || busy[0] !== 1'b1 || sel[0] !== 3'd2) begin
      bad++; $display("FAIL idle_owner_drop: grant=%b busy_L=%b sel_L=%0d want 00000/1/2", gnt, busy[0], sel[0]);
    end
    cyc();
    #1;
    total++;
    if (gnt !== 5'b0 || busy[0] !== 1'b1 || sel[0] !== 3'd2) begin
      bad++; $display("FAIL idle_held: grant=%b busy_L=%b sel_L=%0d want 00000/1/2", gnt, busy[0], sel[0]);
    end
    req[2]  = 3'd0;
    tail[2] = 1'b1;
    #1;
    total++;
    if (gnt !== 5'b00100) begin
      bad++; $display("FAIL idle_tail: grant=%b want 00100", gnt);
    end
    cyc();
    req[2]  = 3'd7;
    tail[2] = 1'b0;
    #1;
    total++;
    if (sel[0] !== 3'd7 || busy[0] !== 1'b0 || gnt !== 5'b0) begin
      bad++; $display("FAIL idle_released: sel_L=%0d busy_L=%b grant=%b want 7/0/00000", sel[0], busy[0], gnt);
    end
    cyc();
    #1;
    total++;
    if (sel[0] !== 3'd3 || gnt !== 5'b01000) begin
      bad++; $display("FAIL idle_waiter: sel_L=%0d grant=%b want 3/01000", sel[0], gnt);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req[0] = 3'd1;
    cyc();
    #1;
    total++;
    if (busy[1] !== 1'b1) begin
      bad++; $display("FAIL rmid_locked: busy_N=%b want 1", busy[1]);
    end
    rst = 1'b0;
    cyc();
    #1;
    total++;
    if (busy !== 5'b0 || sel[1] !== 3'd7 || gnt !== 5'b0) begin
      bad++; $display("FAIL rmid_drop: busy=%b sel_N=%0d grant=%b want 00000/7/00000", busy, sel[1], gnt);
    end
    rst = 1'b1;
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_wormhole();
    test_backpressure();
    test_parallel();
    test_idle_codes();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
